// File: rtl/xlr_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module     : xlr_mem_pkg
// Description: Shared types and constants for the accelerator line-memory
//              arbiter (requester ids, memory read latency).
// Revision   : 1.0 - initial release
// ============================================================================
package xlr_mem_pkg;

    // Requester identity carried through the read tag pipeline
    typedef enum logic {
        REQ_XLR  = 1'b0,
        REQ_HOST = 1'b1
    } xlr_req_id_t;

    // Memory returns read data this many cycles after xlr_mem_rd
    localparam int XLR_MEM_RD_LAT = 1;

endpackage
`default_nettype wire

// File: rtl/xlr_mem_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module     : xlr_mem_arb_rr2
// Description: Single-bank two-way round-robin arbiter with a registered
//              memory command stage and a one-deep read tag that steers the
//              returning line to the requester that issued the read.
// Revision   : 1.0 - initial release
// ============================================================================
module xlr_mem_arb_rr2
    import xlr_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                r0_req_i,
    input  logic                r0_wr_i,
    input  logic [ADDR_W-1:0]   r0_addr_i,
    input  logic [DATA_W-1:0]   r0_wdata_i,
    input  logic [DATA_W/8-1:0] r0_be_i,
    input  logic                r1_req_i,
    input  logic                r1_wr_i,
    input  logic [ADDR_W-1:0]   r1_addr_i,
    input  logic [DATA_W-1:0]   r1_wdata_i,
    input  logic [DATA_W/8-1:0] r1_be_i,
    output logic                r0_gnt_o,
    output logic                r1_gnt_o,
    output logic                r0_rvalid_o,
    output logic                r1_rvalid_o,
    output logic [DATA_W-1:0]   r0_rdata_o,
    output logic [DATA_W-1:0]   r1_rdata_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic                mem_rd_o,
    output logic                mem_wr_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int BE_W = DATA_W / 8;

    xlr_req_id_t        last_q, last_d;
    xlr_req_id_t        win_id;
    logic               gnt_any;
    logic               sel_wr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [BE_W-1:0]    sel_be;

    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    xlr_req_id_t        tag_q, tag_d;

    // Response stage: memory data is valid one cycle after rd_q (XLR_MEM_RD_LAT)
    logic               rsp_vld_q;
    xlr_req_id_t        rsp_id_q;
    logic [DATA_W-1:0]  r0_rdata_q, r1_rdata_q;
    logic               dlv0, dlv1;

    // Winner selection: under contention the requester that did not win last time
    always_comb begin
        win_id = REQ_XLR;
        if (r0_req_i && r1_req_i) begin
            win_id = (last_q == REQ_XLR) ? REQ_HOST : REQ_XLR;
        end else if (r1_req_i) begin
            win_id = REQ_HOST;
        end
        // Grants are suppressed while reset is held, independent of the clock
        gnt_any   = rst_n && (r0_req_i || r1_req_i);
        r0_gnt_o  = gnt_any && (win_id == REQ_XLR);
        r1_gnt_o  = gnt_any && (win_id == REQ_HOST);
        sel_wr    = (win_id == REQ_HOST) ? r1_wr_i    : r0_wr_i;
        sel_addr  = (win_id == REQ_HOST) ? r1_addr_i  : r0_addr_i;
        sel_wdata = (win_id == REQ_HOST) ? r1_wdata_i : r0_wdata_i;
        sel_be    = (win_id == REQ_HOST) ? r1_be_i    : r0_be_i;
    end

    // Next command: strobes and byte enables pulse only on a grant; addr/wdata hold
    always_comb begin
        last_d  = last_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        be_d    = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tag_d   = tag_q;
        if (gnt_any) begin
            last_d  = win_id;
            rd_d    = !sel_wr;
            wr_d    = sel_wr;
            be_d    = sel_wr ? sel_be : '0;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            tag_d   = win_id;
        end
    end

    // Command register, round-robin pointer and read tag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= REQ_HOST;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tag_q      <= REQ_XLR;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= REQ_XLR;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
        end else begin
            last_q     <= last_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tag_q      <= tag_d;
            rsp_vld_q  <= rd_q;
            rsp_id_q   <= tag_q;
            if (dlv0) begin
                r0_rdata_q <= mem_rdata_i;
            end
            if (dlv1) begin
                r1_rdata_q <= mem_rdata_i;
            end
        end
    end

    // The issuing requester sees live memory data; the other keeps its last line
    always_comb begin
        dlv0        = rsp_vld_q && (rsp_id_q == REQ_XLR);
        dlv1        = rsp_vld_q && (rsp_id_q == REQ_HOST);
        r0_rvalid_o = dlv0;
        r1_rvalid_o = dlv1;
        r0_rdata_o  = dlv0 ? mem_rdata_i : r0_rdata_q;
        r1_rdata_o  = dlv1 ? mem_rdata_i : r1_rdata_q;
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign mem_rd_o    = rd_q;
    assign mem_wr_o    = wr_q;

endmodule
`default_nettype wire

// File: rtl/xlr_mem_arb.sv
`default_nettype none
// ============================================================================
// Module     : xlr_mem_arb
// Description: Per-bank round-robin arbiter sharing the accelerator line
//              memory between the accelerator core (r0) and the host (r1).
//              Each bank is an independent xlr_mem_arb_rr2 instance.
// Revision   : 1.0 - initial release
// ============================================================================
module xlr_mem_arb
    import xlr_mem_pkg::*;
#(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 8,
    parameter int MEM_DATA_W         = 256
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_MEMS-1:0]                           r0_req,
    input  logic [NUM_MEMS-1:0]                           r0_wr,
    input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]   r0_addr,
    input  logic [NUM_MEMS-1:0][MEM_DATA_W-1:0]           r0_wdata,
    input  logic [NUM_MEMS-1:0][MEM_DATA_W/8-1:0]         r0_be,
    output logic [NUM_MEMS-1:0]                           r0_gnt,
    output logic [NUM_MEMS-1:0]                           r0_rvalid,
    output logic [NUM_MEMS-1:0][MEM_DATA_W-1:0]           r0_rdata,
    input  logic [NUM_MEMS-1:0]                           r1_req,
    input  logic [NUM_MEMS-1:0]                           r1_wr,
    input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]   r1_addr,
    input  logic [NUM_MEMS-1:0][MEM_DATA_W-1:0]           r1_wdata,
    input  logic [NUM_MEMS-1:0][MEM_DATA_W/8-1:0]         r1_be,
    output logic [NUM_MEMS-1:0]                           r1_gnt,
    output logic [NUM_MEMS-1:0]                           r1_rvalid,
    output logic [NUM_MEMS-1:0][MEM_DATA_W-1:0]           r1_rdata,
    output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]   xlr_mem_addr,
    output logic [NUM_MEMS-1:0][MEM_DATA_W-1:0]           xlr_mem_wdata,
    output logic [NUM_MEMS-1:0][MEM_DATA_W/8-1:0]         xlr_mem_be,
    output logic [NUM_MEMS-1:0]                           xlr_mem_rd,
    output logic [NUM_MEMS-1:0]                           xlr_mem_wr,
    input  logic [NUM_MEMS-1:0][MEM_DATA_W-1:0]           xlr_mem_rdata
);

    // One fully independent arbiter per bank
    for (genvar b = 0; b < NUM_MEMS; b++) begin : g_bank
        xlr_mem_arb_rr2 #(
            .ADDR_W (LOG2_LINES_PER_MEM),
            .DATA_W (MEM_DATA_W)
        ) u_rr2 (
            .clk         (clk),
            .rst_n       (rst_n),
            .r0_req_i    (r0_req[b]),
            .r0_wr_i     (r0_wr[b]),
            .r0_addr_i   (r0_addr[b]),
            .r0_wdata_i  (r0_wdata[b]),
            .r0_be_i     (r0_be[b]),
            .r1_req_i    (r1_req[b]),
            .r1_wr_i     (r1_wr[b]),
            .r1_addr_i   (r1_addr[b]),
            .r1_wdata_i  (r1_wdata[b]),
            .r1_be_i     (r1_be[b]),
            .r0_gnt_o    (r0_gnt[b]),
            .r1_gnt_o    (r1_gnt[b]),
            .r0_rvalid_o (r0_rvalid[b]),
            .r1_rvalid_o (r1_rvalid[b]),
            .r0_rdata_o  (r0_rdata[b]),
            .r1_rdata_o  (r1_rdata[b]),
            .mem_addr_o  (xlr_mem_addr[b]),
            .mem_wdata_o (xlr_mem_wdata[b]),
            .mem_be_o    (xlr_mem_be[b]),
            .mem_rd_o    (xlr_mem_rd[b]),
            .mem_wr_o    (xlr_mem_wr[b]),
            .mem_rdata_i (xlr_mem_rdata[b])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_xlr_mem_arb.sv
`default_nettype none
// ============================================================================
// Module     : tb_xlr_mem_arb
// Description: Directed bench for xlr_mem_arb with a byte-enable line memory
//              model that answers reads one cycle after xlr_mem_rd.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_xlr_mem_arb;

    localparam int NM = 2;
    localparam int AW = 8;
    localparam int DW = 256;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;

    logic [NM-1:0]         r0_req, r0_wr, r1_req, r1_wr;
    logic [NM-1:0][AW-1:0] r0_addr, r1_addr;
    logic [NM-1:0][DW-1:0] r0_wdata, r1_wdata;
    logic [NM-1:0][BW-1:0] r0_be, r1_be;
    logic [NM-1:0]         r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [NM-1:0][DW-1:0] r0_rdata, r1_rdata;
    logic [NM-1:0][AW-1:0] xlr_mem_addr;
    logic [NM-1:0][DW-1:0] xlr_mem_wdata;
    logic [NM-1:0][BW-1:0] xlr_mem_be;
    logic [NM-1:0]         xlr_mem_rd, xlr_mem_wr;
    logic [NM-1:0][DW-1:0] xlr_mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    xlr_mem_arb #(
        .NUM_MEMS           (NM),
        .LOG2_LINES_PER_MEM (AW),
        .MEM_DATA_W         (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .r0_req        (r0_req),
        .r0_wr         (r0_wr),
        .r0_addr       (r0_addr),
        .r0_wdata      (r0_wdata),
        .r0_be         (r0_be),
        .r0_gnt        (r0_gnt),
        .r0_rvalid     (r0_rvalid),
        .r0_rdata      (r0_rdata),
        .r1_req        (r1_req),
        .r1_wr         (r1_wr),
        .r1_addr       (r1_addr),
        .r1_wdata      (r1_wdata),
        .r1_be         (r1_be),
        .r1_gnt        (r1_gnt),
        .r1_rvalid     (r1_rvalid),
        .r1_rdata      (r1_rdata),
        .xlr_mem_addr  (xlr_mem_addr),
        .xlr_mem_wdata (xlr_mem_wdata),
        .xlr_mem_be    (xlr_mem_be),
        .xlr_mem_rd    (xlr_mem_rd),
        .xlr_mem_wr    (xlr_mem_wr),
        .xlr_mem_rdata (xlr_mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: each line powers up as A5 bytes with the address in byte 0
    function automatic logic [DW-1:0] line_init(input logic [AW-1:0] a);
        return {{31{8'hA5}}, a};
    endfunction

    logic [DW-1:0] mem_model [NM][256];

    // Line memory: byte-enabled writes, registered reads
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NM; b++) begin
                for (int a = 0; a < 256; a++) begin
                    mem_model[b][a] <= line_init(8'(a));
                end
            end
            xlr_mem_rdata <= '0;
        end else begin
            for (int b = 0; b < NM; b++) begin
                if (xlr_mem_wr[b]) begin
                    for (int k = 0; k < BW; k++) begin
                        if (xlr_mem_be[b][k]) begin
                            mem_model[b][xlr_mem_addr[b]][8*k +: 8] <= xlr_mem_wdata[b][8*k +: 8];
                        end
                    end
                end
                if (xlr_mem_rd[b]) begin
                    xlr_mem_rdata[b] <= mem_model[b][xlr_mem_addr[b]];
                end
            end
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Advance to just after the next rising edge, where inputs are driven
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_req = '0; r0_wr = '0; r0_addr = '0; r0_wdata = '0; r0_be = '0;
        r1_req = '0; r1_wr = '0; r1_addr = '0; r1_wdata = '0; r1_be = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Grant-sequence vectors on bank 0; bit order matches field order
    typedef struct packed {
        logic r0_req, r0_wr, r1_req, r1_wr;
        logic exp_g0, exp_g1, exp_rd, exp_wr;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] ea, a0, a1;
        logic          g0s, g1s;
        int            n0, n1;

        // last starts at HOST, so the first contention goes to r0
        vecs[0] = 8'b1010_1010;  // both rd      -> r0, rd
        vecs[1] = 8'b1011_0101;  // r0 rd, r1 wr -> r1, wr
        vecs[2] = 8'b0000_0000;  // idle
        vecs[3] = 8'b0011_0101;  // r1 wr solo   -> r1, wr
        vecs[4] = 8'b1110_1001;  // r0 wr, r1 rd -> r0, wr
        vecs[5] = 8'b1000_1010;  // r0 rd solo   -> r0, rd
        vecs[6] = 8'b1010_0110;  // both rd      -> r1, rd
        vecs[7] = 8'b1111_1001;  // both wr      -> r0, wr
        vecs[8] = 8'b0010_0110;  // r1 rd solo   -> r1, rd
        vecs[9] = 8'b1010_1010;  // both rd      -> r0, rd

        // ---- Reset state, with requests asserted ----
        clear_inputs();
        rst_n  = 1'b0;
        r0_req = '1;
        r1_req = '1;
        repeat (2) @(negedge clk);
        chk1("rst_gnt",    |{r0_gnt, r1_gnt}, 1'b0);
        chk1("rst_rvalid", |{r0_rvalid, r1_rvalid}, 1'b0);
        chk1("rst_cmd",    |{xlr_mem_rd, xlr_mem_wr, xlr_mem_be}, 1'b0);
        chk1("rst_addr",   |{xlr_mem_addr, xlr_mem_wdata}, 1'b0);
        chk1("rst_rdata",  |{r0_rdata, r1_rdata}, 1'b0);
        clear_inputs();
        rst_n = 1'b1;
        tick();

        // ---- Table: grant priority and registered command on bank 0 ----
        for (int i = 0; i < 10; i++) begin
            r0_req[0]   = vecs[i].r0_req;
            r0_wr[0]    = vecs[i].r0_wr;
            r1_req[0]   = vecs[i].r1_req;
            r1_wr[0]    = vecs[i].r1_wr;
            r0_addr[0]  = 8'(i);
            r1_addr[0]  = 8'(8'h80 + i);
            r0_be[0]    = '1;
            r1_be[0]    = '1;
            @(negedge clk);
            chk1($sformatf("tbl%0d_g0", i), r0_gnt[0], vecs[i].exp_g0);
            chk1($sformatf("tbl%0d_g1", i), r1_gnt[0], vecs[i].exp_g1);
            tick();
            ea = vecs[i].exp_g0 ? 8'(i) : 8'(8'h80 + i);
            chk1($sformatf("tbl%0d_rd", i), xlr_mem_rd[0], vecs[i].exp_rd);
            chk1($sformatf("tbl%0d_wr", i), xlr_mem_wr[0], vecs[i].exp_wr);
            chk1($sformatf("tbl%0d_be", i), &xlr_mem_be[0], vecs[i].exp_wr);
            chk1($sformatf("tbl%0d_be0", i), |xlr_mem_be[0], vecs[i].exp_wr);
            if (vecs[i].exp_g0 || vecs[i].exp_g1) begin
                chk8($sformatf("tbl%0d_addr", i), xlr_mem_addr[0], ea);
            end
        end
        clear_inputs();

        // ---- Solo read ----
        do_reset();
        r0_req[0] = 1'b1; r0_addr[0] = 8'h10;
        @(negedge clk);
        chk1("solo_g0", r0_gnt[0], 1'b1);
        chk1("solo_g1", r1_gnt[0], 1'b0);
        tick();
        r0_req[0] = 1'b0;
        @(negedge clk);
        chk1("solo_rd",   xlr_mem_rd[0], 1'b1);
        chk8("solo_addr", xlr_mem_addr[0], 8'h10);
        chk1("solo_early_rvalid", r0_rvalid[0], 1'b0);
        tick();
        @(negedge clk);
        chk1("solo_rvalid", r0_rvalid[0], 1'b1);
        chkw("solo_rdata",  r0_rdata[0], line_init(8'h10));
        chk1("solo_r1_rvalid", |r1_rvalid, 1'b0);

        // ---- First contention after reset ----
        do_reset();
        r0_req[0] = 1'b1; r0_addr[0] = 8'h01;
        r1_req[0] = 1'b1; r1_addr[0] = 8'h02;
        @(negedge clk);
        chk1("fc_g0", r0_gnt[0], 1'b1);
        chk1("fc_g1", r1_gnt[0], 1'b0);
        tick();
        r0_req[0] = 1'b0;
        @(negedge clk);
        chk1("fc_g1_next", r1_gnt[0], 1'b1);
        chk8("fc_addr1",   xlr_mem_addr[0], 8'h01);
        tick();
        r1_req[0] = 1'b0;
        @(negedge clk);
        chk8("fc_addr2",   xlr_mem_addr[0], 8'h02);
        chk1("fc_r0_rv",   r0_rvalid[0], 1'b1);
        chk1("fc_r1_rv0",  r1_rvalid[0], 1'b0);
        chkw("fc_r0_data", r0_rdata[0], line_init(8'h01));
        tick();
        @(negedge clk);
        chk1("fc_r1_rv",   r1_rvalid[0], 1'b1);
        chk1("fc_r0_rv0",  r0_rvalid[0], 1'b0);
        chkw("fc_r1_data", r1_rdata[0], line_init(8'h02));

        // ---- Sustained contention on bank 1 ----
        do_reset();
        a0 = 8'h00; a1 = 8'h80; n0 = 0; n1 = 0;
        r0_req[1] = 1'b1; r1_req[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r0_addr[1] = a0;
            r1_addr[1] = a1;
            @(negedge clk);
            g0s = r0_gnt[1];
            g1s = r1_gnt[1];
            chk1($sformatf("sus%0d_g0", i), g0s, (i % 2) == 0);
            chk1($sformatf("sus%0d_g1", i), g1s, (i % 2) == 1);
            tick();
            if (g0s) begin
                chk8($sformatf("sus%0d_addr", i), xlr_mem_addr[1], a0);
                a0 = a0 + 8'd1; n0++;
            end
            if (g1s) begin
                chk8($sformatf("sus%0d_addr", i), xlr_mem_addr[1], a1);
                a1 = a1 + 8'd1; n1++;
            end
        end
        r0_req[1] = 1'b0; r1_req[1] = 1'b0;
        chk8("sus_n0", 8'(n0), 8'd4);
        chk8("sus_n1", 8'(n1), 8'd4);
        tick();

        // ---- Parallel banks: r0 writes bank 0, r1 reads bank 1 ----
        r0_req[0] = 1'b1; r0_wr[0] = 1'b1; r0_addr[0] = 8'h20; r0_be[0] = '1;
        r0_wdata[0] = {8{32'h1234_5678}};
        r1_req[1] = 1'b1; r1_wr[1] = 1'b0; r1_addr[1] = 8'h30;
        @(negedge clk);
        chk1("par_g0b0", r0_gnt[0], 1'b1);
        chk1("par_g1b1", r1_gnt[1], 1'b1);
        tick();
        clear_inputs();
        @(negedge clk);
        chk1("par_wr0", xlr_mem_wr[0], 1'b1);
        chk1("par_rd1", xlr_mem_rd[1], 1'b1);
        chk1("par_be0", &xlr_mem_be[0], 1'b1);
        chk8("par_addr1", xlr_mem_addr[1], 8'h30);
        tick();
        @(negedge clk);
        chk1("par_rv1",   r1_rvalid[1], 1'b1);
        chkw("par_data1", r1_rdata[1], line_init(8'h30));
        chk1("par_rv0",   r0_rvalid[0], 1'b0);

        // ---- Reset while a read is on the memory bus ----
        tick();
        r0_req[0] = 1'b1; r0_addr[0] = 8'h40;
        @(negedge clk);
        chk1("mf_g0", r0_gnt[0], 1'b1);
        tick();
        r0_req[0] = 1'b0;
        chk1("mf_rd_pre", xlr_mem_rd[0], 1'b1);
        #2;
        rst_n = 1'b0;
        r0_req[0] = 1'b1; r1_req[0] = 1'b1;
        #1;
        chk1("mf_rd_rst",   xlr_mem_rd[0], 1'b0);
        chk8("mf_addr_rst", xlr_mem_addr[0], 8'h00);
        chk1("mf_gnt_rst",  |{r0_gnt, r1_gnt}, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1($sformatf("mf_norv%0d", i), |{r0_rvalid, r1_rvalid}, 1'b0);
        end
        tick();
        r0_req[0] = 1'b1; r0_addr[0] = 8'h41;
        r1_req[0] = 1'b1; r1_addr[0] = 8'h42;
        @(negedge clk);
        chk1("mf_fc_g0", r0_gnt[0], 1'b1);
        chk1("mf_fc_g1", r1_gnt[0], 1'b0);
        tick();
        r0_req[0] = 1'b0;
        @(negedge clk);
        chk1("mf_fc_g1n", r1_gnt[0], 1'b1);
        tick();
        r1_req[0] = 1'b0;
        @(negedge clk);
        chkw("mf_r0_data", r0_rdata[0], line_init(8'h41));
        tick();
        @(negedge clk);
        chk1("mf_r1_rv",   r1_rvalid[0], 1'b1);
        chkw("mf_r1_data", r1_rdata[0], line_init(8'h42));

        // ---- Mixed: r1 partial write, then r0 reads the merged line ----
        tick();
        r1_req[0] = 1'b1; r1_wr[0] = 1'b1; r1_addr[0] = 8'h05;
        r1_be[0] = 32'h0000_000F; r1_wdata[0] = 256'hDEAD_BEEF;
        @(negedge clk);
        chk1("mx_g1", r1_gnt[0], 1'b1);
        tick();
        r1_req[0] = 1'b0; r1_wr[0] = 1'b0;
        r0_req[0] = 1'b1; r0_wr[0] = 1'b0; r0_addr[0] = 8'h05;
        @(negedge clk);
        chk1("mx_wr", xlr_mem_wr[0], 1'b1);
        chkw("mx_be_wr", 256'(xlr_mem_be[0]), 256'h0000_000F);
        chk1("mx_g0", r0_gnt[0], 1'b1);
        tick();
        r0_req[0] = 1'b0;
        @(negedge clk);
        chk1("mx_rd", xlr_mem_rd[0], 1'b1);
        chkw("mx_be_rd", 256'(xlr_mem_be[0]), 256'h0);
        chk8("mx_addr", xlr_mem_addr[0], 8'h05);
        tick();
        @(negedge clk);
        chk1("mx_rv",      r0_rvalid[0], 1'b1);
        chkw("mx_data",    r0_rdata[0], {{28{8'hA5}}, 32'hDEAD_BEEF});
        chk1("mx_r1_rv",   r1_rvalid[0], 1'b0);
        chkw("mx_r1_hold", r1_rdata[0], line_init(8'h42));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
